// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and default geometry for the cache-line <-> memory-burst adaptor.
package cacheline_adaptor_pkg;

  localparam int CLA_LINE_W  = 256;
  localparam int CLA_BURST_W = 64;
  localparam int CLA_ADDR_W  = 32;

  localparam int BEATS      = CLA_LINE_W / CLA_BURST_W;
  localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } cla_state_e;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side line port and memory-side burst port; _i/_o suffixes are as seen by the adaptor.
interface cla_cache_if #(
  parameter int LINE_W = cacheline_adaptor_pkg::CLA_LINE_W,
  parameter int ADDR_W = cacheline_adaptor_pkg::CLA_ADDR_W
) ();

  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic [ADDR_W-1:0] address_i;
  logic              read_i;
  logic              write_i;
  logic              resp_o;

  modport master (
    output line_i, address_i, read_i, write_i,
    input  line_o, resp_o
  );

  modport slave (
    input  line_i, address_i, read_i, write_i,
    output line_o, resp_o
  );

endinterface

interface cla_mem_if #(
  parameter int BURST_W = cacheline_adaptor_pkg::CLA_BURST_W,
  parameter int ADDR_W  = cacheline_adaptor_pkg::CLA_ADDR_W
) ();

  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport master (
    input  burst_i, resp_i,
    output burst_o, address_o, read_o, write_o
  );

  modport slave (
    output burst_i, resp_i,
    input  burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Splits a cache line into BEATS memory beats and reassembles reads; request-to-burst 1 cycle,
// last-beat-to-resp_o 1 cycle, resp_i low stalls indefinitely. SVA under CACHELINE_ADAPTOR_ASSERT_EN.
module cacheline_adaptor #(
  parameter int LINE_W  = cacheline_adaptor_pkg::CLA_LINE_W,
  parameter int BURST_W = cacheline_adaptor_pkg::CLA_BURST_W,
  parameter int ADDR_W  = cacheline_adaptor_pkg::CLA_ADDR_W
) (
  input  logic        clk,
  input  logic        rst,
  cla_cache_if.slave  cache,
  cla_mem_if.master   mem
);

  import cacheline_adaptor_pkg::*;

  localparam int NBEATS = LINE_W / BURST_W;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  cla_state_e        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_beat;

  assign last_beat = mem.resp_i && (cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    line_d  = line_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Read has priority when both requests are raised together.
        if (cache.read_i) begin
          addr_d  = {cache.address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d = RD;
        end else if (cache.write_i) begin
          addr_d  = {cache.address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          buf_d   = cache.line_i;
          state_d = WR;
        end
      end
      RD: begin
        if (mem.resp_i) begin
          buf_d[cnt_q*BURST_W +: BURST_W] = mem.burst_i;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            line_d  = buf_d;
            state_d = DONE;
          end
        end
      end
      WR: begin
        if (mem.resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign mem.read_o    = (state_q == RD);
  assign mem.write_o   = (state_q == WR);
  assign mem.address_o = addr_q;
  assign mem.burst_o   = (state_q == WR) ? buf_q[cnt_q*BURST_W +: BURST_W] : '0;
  assign cache.resp_o  = (state_q == DONE);
  assign cache.line_o  = line_q;

`ifdef CACHELINE_ADAPTOR_ASSERT_EN
  a_no_resp_in_idle: assert property (@(posedge clk) disable iff (!rst)
    (state_q == IDLE) |-> !mem.resp_i);
  a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(cache.read_i && cache.write_i));
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
    (cache.read_i || cache.write_i) |=> (!(cache.read_i || cache.write_i) || $stable(cache.address_i)));
  a_resp_single: assert property (@(posedge clk) disable iff (!rst)
    cache.resp_o |=> !cache.resp_o);
`else
  // Assertions compiled out; datapath and FSM are unchanged.
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor with a queue-based scoreboard and negedge monitor.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  typedef struct {
    logic [255:0] line;
    logic [31:0]  addr;
  } exp_resp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  exp_resp_t    exp_resp_q[$];
  logic [63:0]  exp_beat_q[$];
  logic [255:0] last_line;

  cla_cache_if cache_bus ();
  cla_mem_if   mem_bus ();

  cacheline_adaptor dut (
    .clk   (clk),
    .rst   (rst),
    .cache (cache_bus),
    .mem   (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a write beat or a completion.
  always @(negedge clk) begin
    exp_resp_t   er;
    logic [63:0] eb;
    if (rst) begin
      if (mem_bus.write_o && mem_bus.resp_i) begin
        if (exp_beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_beat_unexpected: got %h expected none", mem_bus.burst_o);
        end else begin
          eb = exp_beat_q.pop_front();
          chk("wr_beat", 256'(mem_bus.burst_o), 256'(eb));
        end
      end
      if (cache_bus.resp_o) begin
        if (exp_resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: got resp_o=1 expected 0");
        end else begin
          er = exp_resp_q.pop_front();
          chk("resp_addr", 256'(mem_bus.address_o), 256'(er.addr));
          chk("resp_line", cache_bus.line_o, er.line);
        end
      end
    end
  end

  task automatic idle_inputs();
    cache_bus.read_i    = 1'b0;
    cache_bus.write_i   = 1'b0;
    cache_bus.address_i = '0;
    cache_bus.line_i    = '0;
    mem_bus.resp_i      = 1'b0;
    mem_bus.burst_i     = '0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3,
                         input logic [15:0] pat, input int plen, input bit also_write);
    logic [63:0]  beats [4];
    logic [255:0] line;
    int k;
    beats = '{b0, b1, b2, b3};
    line  = {b3, b2, b1, b0};
    exp_resp_q.push_back('{line: line, addr: exp_addr});
    @(posedge clk); #1;
    cache_bus.read_i    = 1'b1;
    cache_bus.write_i   = also_write;
    cache_bus.address_i = addr;
    cache_bus.line_i    = {4{64'hDEAD_BEEF_CAFE_F00D}};
    @(posedge clk); #1;
    cache_bus.address_i = ~addr;
    k = 0;
    for (int i = 0; i < plen; i++) begin
      chk("rd_read_o", 256'(mem_bus.read_o), 256'(1));
      chk("rd_write_o", 256'(mem_bus.write_o), 256'(0));
      mem_bus.resp_i  = pat[plen-1-i];
      mem_bus.burst_i = pat[plen-1-i] ? beats[k] : 64'hBAD0_BAD0_BAD0_BAD0;
      @(posedge clk); #1;
      if (pat[plen-1-i]) k++;
    end
    mem_bus.resp_i  = 1'b0;
    mem_bus.burst_i = '0;
    chk("rd_resp_latency", 256'(cache_bus.resp_o), 256'(1));
    chk("rd_read_o_drop", 256'(mem_bus.read_o), 256'(0));
    @(posedge clk); #1;
    cache_bus.read_i  = 1'b0;
    cache_bus.write_i = 1'b0;
    chk("rd_resp_pulse", 256'(cache_bus.resp_o), 256'(0));
    last_line = line;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [255:0] line, input logic [15:0] pat, input int plen);
    for (int b = 0; b < 4; b++) exp_beat_q.push_back(line[b*64 +: 64]);
    exp_resp_q.push_back('{line: last_line, addr: exp_addr});
    @(posedge clk); #1;
    cache_bus.write_i   = 1'b1;
    cache_bus.address_i = addr;
    cache_bus.line_i    = line;
    @(posedge clk); #1;
    cache_bus.address_i = ~addr;
    cache_bus.line_i    = ~line;
    for (int i = 0; i < plen; i++) begin
      chk("wr_write_o", 256'(mem_bus.write_o), 256'(1));
      chk("wr_read_o", 256'(mem_bus.read_o), 256'(0));
      mem_bus.resp_i  = pat[plen-1-i];
      mem_bus.burst_i = 64'(($urandom() << 32) | $urandom());
      @(posedge clk); #1;
    end
    mem_bus.resp_i = 1'b0;
    chk("wr_resp_latency", 256'(cache_bus.resp_o), 256'(1));
    chk("wr_write_o_drop", 256'(mem_bus.write_o), 256'(0));
    @(posedge clk); #1;
    cache_bus.write_i = 1'b0;
    chk("wr_resp_pulse", 256'(cache_bus.resp_o), 256'(0));
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [255:0] wline;
    checks    = 0;
    errors    = 0;
    last_line = '0;
    rst       = 1'b0;
    idle_inputs();

    // Reset with noisy inputs: every output must stay at zero.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      cache_bus.read_i    = 1'($urandom());
      cache_bus.write_i   = 1'($urandom());
      cache_bus.address_i = $urandom();
      cache_bus.line_i    = {8{$urandom()}};
      mem_bus.resp_i      = 1'($urandom());
      mem_bus.burst_i     = {$urandom(), $urandom()};
      #1;
      chk("rst_read_o", 256'(mem_bus.read_o), 256'(0));
      chk("rst_write_o", 256'(mem_bus.write_o), 256'(0));
      chk("rst_resp_o", 256'(cache_bus.resp_o), 256'(0));
      chk("rst_burst_o", 256'(mem_bus.burst_o), 256'(0));
      chk("rst_address_o", 256'(mem_bus.address_o), 256'(0));
      chk("rst_line_o", cache_bus.line_o, 256'(0));
      chk("rst_state", 256'(dut.state_q), 256'(IDLE));
    end
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;

    // Plain read, four back-to-back beats.
    do_read(32'h1234_5678, 32'h1234_5660,
            64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
            16'b1111, 4, 1'b0);

    // Plain write; line_o must still show the previous read.
    wline = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
    do_write(32'hABCD_EF3F, 32'hABCD_EF20, wline, 16'b1111, 4);

    // Read with stalls between beats.
    do_read(32'h0000_1FFF, 32'h0000_1FE0,
            64'hA5A5_0000_0000_0001, 64'h5A5A_0000_0000_0002,
            64'hFFFF_0000_0000_0003, 64'h0F0F_0000_0000_0004,
            16'b1001011, 7, 1'b0);

    // Write with stalls.
    do_write(32'h8000_0001, 32'h8000_0000, ~wline, 16'b101101, 6);

    // Write abandoned by reset after two beats.
    exp_beat_q.push_back(wline[63:0]);
    exp_beat_q.push_back(wline[127:64]);
    @(posedge clk); #1;
    cache_bus.write_i   = 1'b1;
    cache_bus.address_i = 32'h4000_0040;
    cache_bus.line_i    = wline;
    @(posedge clk); #1;
    mem_bus.resp_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_bus.resp_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_write_o", 256'(mem_bus.write_o), 256'(0));
    chk("abort_resp_o", 256'(cache_bus.resp_o), 256'(0));
    chk("abort_address_o", 256'(mem_bus.address_o), 256'(0));
    chk("abort_line_o", cache_bus.line_o, 256'(0));
    chk("abort_beats_left", 256'(exp_beat_q.size()), 256'(0));
    idle_inputs();
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_resp", 256'(cache_bus.resp_o), 256'(0));
    end
    rst = 1'b1;
    last_line = '0;

    do_read(32'h0000_0020, 32'h0000_0020,
            64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
            64'h2122_2324_2526_2728, 64'h3132_3334_3536_3738,
            16'b1111, 4, 1'b0);

    // Read and write raised together: only a read burst may happen.
    do_read(32'h7777_777F, 32'h7777_7760,
            64'hC0C0_C0C0_C0C0_C0C0, 64'hC1C1_C1C1_C1C1_C1C1,
            64'hC2C2_C2C2_C2C2_C2C2, 64'hC3C3_C3C3_C3C3_C3C3,
            16'b11011, 5, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_resp_drained", 256'(exp_resp_q.size()), 256'(0));
    chk("sb_beats_drained", 256'(exp_beat_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
